dcache_req_frontend: RTL and testbench
======================================

# dcache_req_frontend

Parametrised request front end for the DRAM cache controller. Accepts AXI read (AR) and write (AW) address requests from the processor, arbitrates them round-robin, tags each with a rolling transaction ID, and buffers `{is_write, addr, tid}` entries in an internal FIFO of configurable depth for the tag-compare stage. Optionally forwards accepted reads to the memory controller in parallel, as a speculative fetch. It succeeds the fixed-size extractor and tag-FIFO pair: depth, thresholds and TID width are generic, and it adds arbitration fairness, a fill count and overflow/underflow flags.

## Interface
- ADDR_WIDTH, 64, request address width
- ID_WIDTH, 8, AXI ID width
- TID_WIDTH, 16, internal transaction ID width
- FIFO_DEPTH, 16, entry count; power of two, at least 4
- AFULL_LEVEL, FIFO_DEPTH-2, `afull_o` asserts when count >= this value
- AEMPTY_LEVEL, 1, `aempty_o` asserts when count <= this value
- ENTRY_W, 1+ADDR_WIDTH+TID_WIDTH, derived FIFO entry width; not overridable

Ports:
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- arid_i / araddr_i / arlen_i  in  ID_WIDTH / ADDR_WIDTH / 8  processor read request
- arvalid_i  in  1 ; arready_o  out  1  processor read handshake
- awid_i / awaddr_i / awlen_i  in  ID_WIDTH / ADDR_WIDTH / 8  processor write request
- awvalid_i  in  1 ; awready_o  out  1  processor write handshake
- arid_o / araddr_o / arlen_o  out  ID_WIDTH / ADDR_WIDTH / 8  forwarded read to the memory controller
- arvalid_o  out  1 ; arready_i  in  1  memory-controller handshake
- data_o  out  ENTRY_W  FIFO head, `{is_write, addr, tid}` with is_write as the MSB
- rden_i  in  1  pop request
- empty_o  out  1 ; aempty_o  out  1 ; afull_o  out  1  FIFO status
- count_o  out  $clog2(FIFO_DEPTH)+1  current occupancy
- err_o  out  2  sticky flags; bit0 = pop while empty, bit1 = internal overflow

## Operation
- FIFO is first-word-fall-through. `data_o` holds the head entry whenever `empty_o` is 0. When empty, `data_o` is 0.
- `space` is true when count < FIFO_DEPTH. It is computed from registered count only and does not depend on `rden_i`.
- `fwd_ok` is true when `!arvalid_o || arready_i`. It is forced to 1 when forwarding is compiled out.
- Arbitration uses a registered priority bit `rr_pri` (0 = read first).
  - Both valid and eligible: the prioritised side is granted and `rr_pri` toggles.
  - Only one valid: that side is granted if eligible; `rr_pri` is unchanged.
  - At most one grant per cycle.
- Read eligibility: `space && fwd_ok`. Write eligibility: `space`.
- `arready_o` / `awready_o` equal the grant for that side; they are low when the matching valid is low.
- Accepted request:
  - Entry `{is_write, addr, tid_ctr}` is written.
  - `tid_ctr` (TID_WIDTH bits) increments and wraps modulo 2^TID_WIDTH.
  - `arlen_i` / `awlen_i` are not stored.
- Read forwarding: on AR accept, `arid_o`, `araddr_o` and `arlen_o` are registered from the inputs and `arvalid_o` is set. `arvalid_o` holds with stable payload until `arready_i`. A new read accepted in the same cycle as `arready_i` reloads the payload with no bubble.
- Pop: `rden_i && !empty_o` advances the head.
  - `rden_i` while empty is ignored and sets `err_o[0]`.
  - Push and pop in the same cycle leave the count unchanged.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.
- `err_o[1]` sets if a write happens at count == FIFO_DEPTH. This cannot happen in a correct implementation; it is an assertion hook.
- `err_o` bits clear only on reset.

## Timing
- Reset values: count 0, pointers 0, `rr_pri` 0, `tid_ctr` 0, `arvalid_o` 0, `arid_o` / `araddr_o` / `arlen_o` 0, `err_o` 0, `empty_o` 1, `aempty_o` 1, `afull_o` 0, `data_o` 0.
- Reset asserted mid-operation discards all entries and any pending forward immediately; nothing is replayed.
- Handshake at edge N: entry is visible on `data_o` and `empty_o` falls after edge N, one cycle of latency.
- Pop at edge N: the next entry (or empty) is visible after edge N.
- `arvalid_o` rises the cycle after the AR handshake.
- Status flags and `count_o` are registered-state decodes with no combinational path from `rden_i`.
- Ready outputs are combinational from the valids, `arready_i` and registered state only.
- Full FIFO: both readies are 0 even if `rden_i` is 1 that cycle. Acceptance resumes the cycle after the pop.

## Configuration
- `DCACHE_FE_RD_FORWARD_EN` defined: speculative read forwarding as described above.
- Undefined:
  - `arvalid_o` is tied 0; `arid_o`, `araddr_o` and `arlen_o` are tied 0; `arready_i` is ignored.
  - Read eligibility is `space` only.
  - All other behaviour is identical.

## Test plan
- Reset, then a single AR with addr 0x1000 and `arready_i` = 1: `arready_o` is 1 the same cycle. Next cycle `data_o` = `{0, 0x1000, 0x0000}`, count 1, and `arvalid_o` pulses for one cycle.
- Hold `arvalid_i` and `awvalid_i` high continuously for 8 cycles: grants alternate R, W, R, W and TIDs run 0..7.
- Fill to 16 with no pops: `afull_o` rises at 14, readies drop at 16. Pop once: acceptance resumes one cycle later. `err_o` stays 0.
- Hold `arready_i` low after one forwarded read: further ARs stall and AWs are still accepted. Raise `arready_i`: a queued AR is accepted in the same cycle and `arvalid_o` stays high with the new payload.
- Simultaneous push and pop at count 5: count stays 5 and the order is preserved. Pop on empty: `err_o` = 2'b01.
- Assert `rst_n` low with 6 entries and `arvalid_o` high: all outputs return to their reset values asynchronously. Run this with the macro both defined and undefined.

Source files
------------

// File: rtl/dcache_req_frontend.sv
// dcache_req_frontend
//   Request front end for the DRAM cache controller. Arbitrates processor AR/AW
//   address requests round-robin, stamps each with a rolling transaction ID and
//   queues {is_write, addr, tid} in a first-word-fall-through FIFO for the
//   tag-compare stage.
//
//   Optional feature macro: DCACHE_FE_RD_FORWARD_EN
//     defined   - accepted reads are also forwarded to the memory controller as
//                 a speculative fetch (arvalid_o/arready_i handshake).
//     undefined - forward port tied 0, arready_i ignored.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   ar*_i / arvalid_i / arready_o   processor read request
//   aw*_i / awvalid_i / awready_o   processor write request
//   ar*_o / arvalid_o / arready_i   forwarded read to memory controller
//   data_o                          FIFO head {is_write, addr, tid}, 0 when empty
//   rden_i                          pop
//   empty_o aempty_o afull_o        FIFO status (registered-state decodes)
//   count_o                         occupancy
//   err_o                           sticky: [0] pop while empty, [1] overflow
module dcache_req_frontend #(
  parameter int ADDR_WIDTH   = 64,
  parameter int ID_WIDTH     = 8,
  parameter int TID_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_LEVEL  = FIFO_DEPTH - 2,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ID_WIDTH-1:0]               arid_i,
  input  logic [ADDR_WIDTH-1:0]             araddr_i,
  input  logic [7:0]                        arlen_i,
  input  logic                              arvalid_i,
  output logic                              arready_o,
  input  logic [ID_WIDTH-1:0]               awid_i,
  input  logic [ADDR_WIDTH-1:0]             awaddr_i,
  input  logic [7:0]                        awlen_i,
  input  logic                              awvalid_i,
  output logic                              awready_o,
  output logic [ID_WIDTH-1:0]               arid_o,
  output logic [ADDR_WIDTH-1:0]             araddr_o,
  output logic [7:0]                        arlen_o,
  output logic                              arvalid_o,
  input  logic                              arready_i,
  output logic [TID_WIDTH+ADDR_WIDTH:0]     data_o,
  input  logic                              rden_i,
  output logic                              empty_o,
  output logic                              aempty_o,
  output logic                              afull_o,
  output logic [$clog2(FIFO_DEPTH):0]       count_o,
  output logic [1:0]                        err_o
);

  localparam int ENTRY_W = 1 + ADDR_WIDTH + TID_WIDTH;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  typedef struct packed {
    logic                  is_write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [TID_WIDTH-1:0]  tid;
  } entry_t;

  entry_t               mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [TID_WIDTH-1:0] tid_ctr;
  logic                 rr_pri;
  logic                 space, fwd_ok, rd_elig, wr_elig;
  logic                 ar_gnt, aw_gnt, push, pop;
  entry_t               wr_entry;

  // Write ID and burst lengths are not carried in the queue.
  logic unused_inputs;
  assign unused_inputs = ^{awid_i, awlen_i, arlen_i, arid_i, arready_i};

  // Registered count only: a same-cycle pop never frees a slot for a push.
  assign space   = count < CNT_W'(FIFO_DEPTH);
  assign rd_elig = arvalid_i && space && fwd_ok;
  assign wr_elig = awvalid_i && space;

  // Round-robin only toggles when both sides actually compete.
  always_comb begin
    ar_gnt = 1'b0;
    aw_gnt = 1'b0;
    if (rd_elig && wr_elig) begin
      if (rr_pri) aw_gnt = 1'b1;
      else        ar_gnt = 1'b1;
    end else begin
      ar_gnt = rd_elig;
      aw_gnt = wr_elig;
    end
  end

  assign arready_o = ar_gnt;
  assign awready_o = aw_gnt;
  assign push      = ar_gnt || aw_gnt;
  assign pop       = rden_i && !empty_o;

  always_comb begin
    wr_entry.is_write = aw_gnt;
    wr_entry.addr     = aw_gnt ? awaddr_i : araddr_i;
    wr_entry.tid      = tid_ctr;
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tid_ctr <= '0;
      rr_pri  <= 1'b0;
      err_o   <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        tid_ctr <= tid_ctr + TID_WIDTH'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      if (rd_elig && wr_elig) rr_pri <= ~rr_pri;
      if (rden_i && empty_o) err_o[0] <= 1'b1;
      if (push && count == CNT_W'(FIFO_DEPTH)) err_o[1] <= 1'b1;
    end
  end

  assign empty_o  = count == '0;
  assign aempty_o = count <= CNT_W'(AEMPTY_LEVEL);
  assign afull_o  = count >= CNT_W'(AFULL_LEVEL);
  assign count_o  = count;
  assign data_o   = empty_o ? '0 : ENTRY_W'(mem[rd_ptr]);

`ifdef DCACHE_FE_RD_FORWARD_EN
  // A pending forward blocks new reads unless it drains this same cycle,
  // so the payload register reloads back-to-back with no bubble.
  assign fwd_ok = !arvalid_o || arready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arvalid_o <= 1'b0;
      arid_o    <= '0;
      araddr_o  <= '0;
      arlen_o   <= '0;
    end else if (ar_gnt) begin
      arvalid_o <= 1'b1;
      arid_o    <= arid_i;
      araddr_o  <= araddr_i;
      arlen_o   <= arlen_i;
    end else if (arready_i) begin
      arvalid_o <= 1'b0;
    end
  end
`else
  assign fwd_ok    = 1'b1;
  assign arvalid_o = 1'b0;
  assign arid_o    = '0;
  assign araddr_o  = '0;
  assign arlen_o   = '0;
`endif

endmodule

// File: tb/tb_dcache_req_frontend.sv
// Self-checking bench for dcache_req_frontend (default parameters). Works with
// DCACHE_FE_RD_FORWARD_EN either defined or undefined.
module tb_dcache_req_frontend;
  localparam int AW = 64, IW = 8, TW = 16, D = 16;
  localparam int EW = 1 + AW + TW, CW = $clog2(D) + 1;
`ifdef DCACHE_FE_RD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [IW-1:0] arid_i, awid_i, arid_o;
  logic [AW-1:0] araddr_i, awaddr_i, araddr_o;
  logic [7:0]    arlen_i, awlen_i, arlen_o;
  logic arvalid_i, arready_o, awvalid_i, awready_o, arvalid_o, arready_i;
  logic [EW-1:0] data_o;
  logic rden_i, empty_o, aempty_o, afull_o;
  logic [CW-1:0] count_o;
  logic [1:0]    err_o;

  dcache_req_frontend dut (
    .clk(clk), .rst_n(rst_n),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i),
    .arvalid_i(arvalid_i), .arready_o(arready_o),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i),
    .awvalid_i(awvalid_i), .awready_o(awready_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i),
    .data_o(data_o), .rden_i(rden_i),
    .empty_o(empty_o), .aempty_o(aempty_o), .afull_o(afull_o),
    .count_o(count_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Reference model: queue of entries plus arbitration/forward state.
  logic [EW-1:0] q[$];
  logic [TW-1:0] m_tid;
  bit            m_rr, m_fv;
  logic [IW-1:0] m_fid;
  logic [AW-1:0] m_faddr;
  logic [7:0]    m_flen;
  logic [1:0]    m_err;
  bit            e_ar, e_aw, s_ar, s_aw;

  task automatic model_reset();
    q.delete();
    m_tid = '0; m_rr = 0; m_fv = 0;
    m_fid = '0; m_faddr = '0; m_flen = '0; m_err = '0;
  endtask

  task automatic idle();
    arvalid_i = 0; awvalid_i = 0; rden_i = 0; arready_i = 1;
    arid_i = '0; awid_i = '0; araddr_i = '0; awaddr_i = '0;
    arlen_i = '0; awlen_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  // Called at posedge+1 with inputs driven; samples readies, clocks, updates
  // the model, returns at the next posedge+1.
  task automatic cycle();
    bit sp, fok, re, we;
    #1;
    sp  = q.size() < D;
    fok = !FWD || !m_fv || arready_i;
    re  = arvalid_i && sp && fok;
    we  = awvalid_i && sp;
    e_ar = re && (!we || !m_rr);
    e_aw = we && (!re || m_rr);
    if (re && we) m_rr = !m_rr;
    s_ar = arready_o; s_aw = awready_o;
    @(posedge clk);
    if (rden_i) begin
      if (q.size() > 0) void'(q.pop_front());
      else m_err[0] = 1'b1;
    end
    if (e_ar) begin q.push_back({1'b0, araddr_i, m_tid}); m_tid++; end
    if (e_aw) begin q.push_back({1'b1, awaddr_i, m_tid}); m_tid++; end
    if (FWD && e_ar) begin
      m_fv = 1; m_fid = arid_i; m_faddr = araddr_i; m_flen = arlen_i;
    end else if (arready_i) m_fv = 0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    #12;
    tests++;
    if (count_o !== '0 || empty_o !== 1 || aempty_o !== 1 || afull_o !== 0 ||
        data_o !== '0 || err_o !== '0 || arvalid_o !== 0 || araddr_o !== '0 ||
        arid_o !== '0 || arlen_o !== '0 || arready_o !== 0 || awready_o !== 0) begin
      fails++;
      $display("FAIL reset_state: cnt=%0d empty=%b aempty=%b afull=%b err=%b arvalid=%b data=%h",
               count_o, empty_o, aempty_o, afull_o, err_o, arvalid_o, data_o);
    end
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_single_read();
    logic [EW-1:0] exp_d;
    exp_d = {1'b0, 64'h1000, 16'h0000};
    idle();
    arvalid_i = 1; araddr_i = 64'h1000; arid_i = 8'h5A; arlen_i = 8'd3;
    cycle();
    arvalid_i = 0;
    tests++;
    if (s_ar !== 1) begin fails++; $display("FAIL single_arready: got %b want 1", s_ar); end
    tests++;
    if (data_o !== exp_d || count_o !== CW'(1) || empty_o !== 0) begin
      fails++; $display("FAIL single_entry: data=%h cnt=%0d want data=%h cnt=1", data_o, count_o, exp_d);
    end
    tests++;
    if (arvalid_o !== FWD || araddr_o !== (FWD ? 64'h1000 : 64'h0) || arid_o !== (FWD ? 8'h5A : 8'h0)) begin
      fails++; $display("FAIL single_fwd: arvalid=%b addr=%h id=%h want arvalid=%b", arvalid_o, araddr_o, arid_o, FWD);
    end
    cycle();
    tests++;
    if (arvalid_o !== 0) begin fails++; $display("FAIL single_fwd_pulse: arvalid=%b want 0", arvalid_o); end
  endtask

  task automatic test_alternate();
    do_reset();
    idle();
    arvalid_i = 1; awvalid_i = 1;
    for (int i = 0; i < 8; i++) begin
      araddr_i = {$urandom, $urandom}; awaddr_i = {$urandom, $urandom};
      cycle();
      tests++;
      if (s_ar !== (i % 2 == 0) || s_aw !== (i % 2 == 1)) begin
        fails++; $display("FAIL alt_grant %0d: ar=%b aw=%b want ar=%b", i, s_ar, s_aw, (i % 2 == 0));
      end
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (data_o[TW-1:0] !== TW'(i) || data_o[EW-1] !== (i % 2 == 1)) begin
        fails++; $display("FAIL alt_tid %0d: tid=%0d wr=%b want tid=%0d", i, data_o[TW-1:0], data_o[EW-1], i);
      end
      rden_i = 1;
      cycle();
    end
    rden_i = 0;
    tests++;
    if (empty_o !== 1) begin fails++; $display("FAIL alt_drain: empty=%b want 1", empty_o); end
  endtask

  task automatic test_fill();
    do_reset();
    idle();
    awvalid_i = 1;
    for (int i = 0; i < D; i++) begin
      awaddr_i = {$urandom, $urandom};
      cycle();
      tests++;
      if (s_aw !== 1 || count_o !== CW'(i + 1) || afull_o !== (i + 1 >= D - 2) || aempty_o !== (i + 1 <= 1)) begin
        fails++; $display("FAIL fill_%0d: aw=%b cnt=%0d afull=%b aempty=%b", i, s_aw, count_o, afull_o, aempty_o);
      end
    end
    arvalid_i = 1; rden_i = 1;
    cycle();
    tests++;
    if (s_ar !== 0 || s_aw !== 0 || count_o !== CW'(D - 1)) begin
      fails++; $display("FAIL full_block: ar=%b aw=%b cnt=%0d want 0 0 %0d", s_ar, s_aw, count_o, D - 1);
    end
    arvalid_i = 0; rden_i = 0;
    cycle();
    tests++;
    if (s_aw !== 1 || count_o !== CW'(D) || err_o !== 2'b00) begin
      fails++; $display("FAIL full_resume: aw=%b cnt=%0d err=%b want 1 %0d 00", s_aw, count_o, err_o, D);
    end
  endtask

  task automatic test_fwd_stall();
    logic [AW-1:0] a1, a2;
    a1 = 64'h0000_1111_2222_3340; a2 = 64'h0000_5555_6666_7780;
    do_reset();
    idle();
    arready_i = 0; arvalid_i = 1; araddr_i = a1;
    cycle();
    araddr_i = a2; awvalid_i = 1; awaddr_i = 64'hBEEF;
    cycle();
    tests++;
    if (s_ar !== !FWD || s_aw !== FWD) begin
      fails++; $display("FAIL stall_grant: ar=%b aw=%b want ar=%b aw=%b", s_ar, s_aw, !FWD, FWD);
    end
    tests++;
    if (arvalid_o !== FWD || araddr_o !== (FWD ? a1 : '0)) begin
      fails++; $display("FAIL stall_hold: arvalid=%b addr=%h", arvalid_o, araddr_o);
    end
    awvalid_i = 0; arready_i = 1;
    cycle();
    tests++;
    if (s_ar !== 1 || arvalid_o !== FWD || araddr_o !== (FWD ? a2 : '0)) begin
      fails++; $display("FAIL stall_reload: ar=%b arvalid=%b addr=%h want 1 %b", s_ar, arvalid_o, araddr_o, FWD);
    end
    arvalid_i = 0;
    cycle();
  endtask

  task automatic test_push_pop();
    do_reset();
    idle();
    awvalid_i = 1;
    for (int i = 0; i < 5; i++) begin awaddr_i = 64'(i); cycle(); end
    awaddr_i = 64'd5; rden_i = 1;
    cycle();
    awvalid_i = 0; rden_i = 0;
    tests++;
    if (count_o !== CW'(5) || data_o !== {1'b1, 64'd1, 16'd1}) begin
      fails++; $display("FAIL push_pop: cnt=%0d data=%h want 5 tid1", count_o, data_o);
    end
    for (int i = 1; i <= 5; i++) begin
      tests++;
      if (data_o !== {1'b1, 64'(i), 16'(i)}) begin
        fails++; $display("FAIL order_%0d: data=%h", i, data_o);
      end
      rden_i = 1;
      cycle();
    end
    cycle();
    rden_i = 0;
    tests++;
    if (err_o !== 2'b01 || empty_o !== 1) begin
      fails++; $display("FAIL pop_empty: err=%b empty=%b want 01 1", err_o, empty_o);
    end
  endtask

  task automatic test_random();
    logic [EW-1:0] exp_d;
    do_reset();
    idle();
    for (int c = 0; c < 600; c++) begin
      arvalid_i = $urandom_range(0, 1); awvalid_i = $urandom_range(0, 1);
      araddr_i = {$urandom, $urandom}; awaddr_i = {$urandom, $urandom};
      arid_i = 8'($urandom); arlen_i = 8'($urandom);
      awid_i = 8'($urandom); awlen_i = 8'($urandom);
      arready_i = ($urandom_range(0, 3) != 0);
      rden_i = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) < 7);
      cycle();
      exp_d = (q.size() > 0) ? q[0] : '0;
      tests++;
      if (s_ar !== e_ar || s_aw !== e_aw) begin
        fails++; $display("FAIL rnd_grant c%0d: ar=%b aw=%b want ar=%b aw=%b", c, s_ar, s_aw, e_ar, e_aw);
      end
      tests++;
      if (data_o !== exp_d || count_o !== CW'(q.size())) begin
        fails++; $display("FAIL rnd_fifo c%0d: data=%h cnt=%0d want %h %0d", c, data_o, count_o, exp_d, q.size());
      end
      tests++;
      if (empty_o !== (q.size() == 0) || aempty_o !== (q.size() <= 1) ||
          afull_o !== (q.size() >= D - 2) || err_o !== m_err) begin
        fails++; $display("FAIL rnd_flags c%0d: e=%b ae=%b af=%b err=%b want err=%b", c, empty_o, aempty_o, afull_o, err_o, m_err);
      end
      tests++;
      if (arvalid_o !== m_fv || araddr_o !== m_faddr || arid_o !== m_fid || arlen_o !== m_flen) begin
        fails++; $display("FAIL rnd_fwd c%0d: v=%b a=%h id=%h len=%h want v=%b a=%h", c, arvalid_o, araddr_o, arid_o, arlen_o, m_fv, m_faddr);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    idle();
    awvalid_i = 1;
    for (int i = 0; i < 5; i++) begin awaddr_i = {$urandom, $urandom}; cycle(); end
    awvalid_i = 0; arvalid_i = 1; arready_i = 0; araddr_i = 64'hABCD; arid_i = 8'h33; arlen_i = 8'h7;
    cycle();
    arvalid_i = 0;
    tests++;
    if (count_o !== CW'(6) || arvalid_o !== FWD) begin
      fails++; $display("FAIL areset_pre: cnt=%0d arvalid=%b want 6 %b", count_o, arvalid_o, FWD);
    end
    #2 rst_n = 0;
    #1;
    tests++;
    if (count_o !== '0 || empty_o !== 1 || aempty_o !== 1 || afull_o !== 0 || data_o !== '0 ||
        err_o !== '0 || arvalid_o !== 0 || araddr_o !== '0 || arid_o !== '0 || arlen_o !== '0) begin
      fails++; $display("FAIL areset_now: cnt=%0d empty=%b arvalid=%b addr=%h data=%h",
                        count_o, empty_o, arvalid_o, araddr_o, data_o);
    end
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    cycle();
    tests++;
    if (count_o !== '0 || arvalid_o !== 0) begin
      fails++; $display("FAIL areset_after: cnt=%0d arvalid=%b", count_o, arvalid_o);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_fill();
    test_fwd_stall();
    test_push_pop();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
